// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 block loader.
//   BLOCK_BITS     : width of one message block
//   LEN_FIELD_BITS : width of the trailing bit-length field
//   PAD_BYTE       : the single '1' bit that opens the padding
//   state_e        : loader FSM states
//   pad_mode_e     : what the pad inserter should build
package sha256_pkg;

  localparam int unsigned BLOCK_BITS     = 512;
  localparam int unsigned BLOCK_BYTES    = BLOCK_BITS / 8;
  localparam int unsigned LEN_FIELD_BITS = 64;
  localparam logic [7:0]  PAD_BYTE       = 8'h80;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SEND = 2'd1,
    PAD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PM_RAW   = 2'd0,  // full 64-byte block, no padding
    PM_LAST  = 2'd1,  // message tail: 0x80 at n, zeros, length if n <= 55
    PM_TRAIL = 2'd2   // trailer block: optional 0x80 at byte 0, zeros, length
  } pad_mode_e;

endpackage

// File: rtl/sha256_pad_insert.sv
// Combinational pad inserter: turns a byte buffer, fill level and bit length
// into a 512-bit big-endian block (bit 0 = MSB of byte 0).
//   buf_i    : buffer contents, byte k at bits [8k +: 8]
//   n_i      : bytes of message in the buffer (0..64)
//   bitlen_i : message length in bits for the length field
//   mode_i   : PM_RAW / PM_LAST / PM_TRAIL
//   block_o  : resulting block
module sha256_pad_insert
  import sha256_pkg::*;
(
  input  logic [0:BLOCK_BITS-1]     buf_i,
  input  logic [6:0]                n_i,
  input  logic [LEN_FIELD_BITS-1:0] bitlen_i,
  input  pad_mode_e                 mode_i,
  output logic [0:BLOCK_BITS-1]     block_o
);

  always_comb begin
    block_o = '0;
    case (mode_i)
      PM_RAW: block_o = buf_i;
      PM_LAST: begin
        for (int unsigned k = 0; k < BLOCK_BYTES; k++) begin
          if (k < 32'(n_i)) begin
            block_o[8*k +: 8] = buf_i[8*k +: 8];
          end else if (k == 32'(n_i)) begin
            block_o[8*k +: 8] = PAD_BYTE;
          end
        end
        // Length only fits when at least 8 bytes remain after the 0x80.
        if (n_i <= 7'd55) begin
          block_o[BLOCK_BITS-LEN_FIELD_BITS +: LEN_FIELD_BITS] = bitlen_i;
        end
      end
      PM_TRAIL: begin
        // n = 64 means the message filled its last block, so the 0x80 lands here.
        if (n_i == 7'd64) begin
          block_o[0 +: 8] = PAD_BYTE;
        end
        block_o[BLOCK_BITS-LEN_FIELD_BITS +: LEN_FIELD_BITS] = bitlen_i;
      end
      default: block_o = '0;
    endcase
  end

endmodule

// File: rtl/sha256_block_loader.sv
// SHA-256 message block loader: collects bytes into 64-byte blocks, applies
// SHA-256 padding and length, and hands blocks to a hash core.
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   byte_in/_valid/_last, byte_ready      : byte input handshake
//   block_out/_valid/_first/_final, block_ready : block output handshake
//   len_ovf           : sticky length-overflow flag (only with
//                       SHA256_LOADER_OVF_EN defined; counter saturates)
// Without SHA256_LOADER_OVF_EN the byte counter wraps modulo 2^LEN_W.
module sha256_block_loader
  import sha256_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  input  logic                  byte_last,
  output logic                  byte_ready,
  output logic [0:BLOCK_BITS-1] block_out,
  output logic                  block_valid,
  input  logic                  block_ready,
  output logic                  block_first,
  output logic                  block_final
`ifdef SHA256_LOADER_OVF_EN
  ,
  output logic                  len_ovf
`endif
);

  state_e                    state_q, state_d;
  logic [0:BLOCK_BITS-1]     buf_q, buf_d, buf_wr;
  logic [5:0]                idx_q, idx_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d, cnt_inc;
  logic [0:BLOCK_BITS-1]     blk_q, blk_d;
  logic                      first_q, first_d;
  logic                      final_q, final_d;
  logic                      pend_q, pend_d;   // trailer block still owed
  logic                      full_q, full_d;   // trailer must carry the 0x80
  logic                      en_q;             // byte_ready gate after reset
  logic                      xfer, hshake;

  logic [6:0]                pad_n;
  logic [LEN_FIELD_BITS-1:0] pad_len;
  pad_mode_e                 pad_mode;
  logic [0:BLOCK_BITS-1]     pad_blk;

  function automatic logic [LEN_FIELD_BITS-1:0] bit_len(input logic [LEN_W-1:0] c);
    return LEN_FIELD_BITS'({c, 3'b000});
  endfunction

`ifdef SHA256_LOADER_OVF_EN
  logic ovf_q, ovf_d;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + LEN_W'(1);
  assign len_ovf = ovf_q;
`else
  assign cnt_inc = cnt_q + LEN_W'(1);
`endif

  assign xfer   = byte_valid && byte_ready;
  assign hshake = block_valid && block_ready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (xfer && (byte_last || idx_q == 6'd63)) state_d = SEND;
      SEND:    if (hshake) state_d = pend_q ? PAD : FILL;
      PAD:     state_d = SEND;
      default: state_d = FILL;
    endcase
  end

  // Output logic
  always_comb begin
    byte_ready  = (state_q == FILL) && en_q;
    block_valid = (state_q == SEND);
    block_out   = blk_q;
    block_first = first_q;
    block_final = final_q;
  end

  always_comb begin
    buf_wr = buf_q;
    buf_wr[{idx_q, 3'b000} +: 8] = byte_in;
  end

  // Pad inserter inputs kept in their own process so the block path through
  // the sub-module is not a loop within one combinational block.
  always_comb begin
    if (state_q == PAD) begin
      pad_mode = PM_TRAIL;
      pad_n    = full_q ? 7'd64 : 7'd0;
      pad_len  = bit_len(cnt_q);
    end else begin
      pad_mode = byte_last ? PM_LAST : PM_RAW;
      pad_n    = {1'b0, idx_q} + 7'd1;
      pad_len  = bit_len(cnt_inc);
    end
  end

  sha256_pad_insert u_pad (
    .buf_i    (buf_wr),
    .n_i      (pad_n),
    .bitlen_i (pad_len),
    .mode_i   (pad_mode),
    .block_o  (pad_blk)
  );

  always_comb begin
    buf_d   = buf_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    first_d = first_q;
    final_d = final_q;
    pend_d  = pend_q;
    full_d  = full_q;
`ifdef SHA256_LOADER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      FILL: begin
        if (xfer) begin
          cnt_d = cnt_inc;
          buf_d = buf_wr;
`ifdef SHA256_LOADER_OVF_EN
          if (cnt_q == '0) ovf_d = 1'b0;
          if (&cnt_q)      ovf_d = 1'b1;
`endif
          if (byte_last) begin
            blk_d   = pad_blk;
            final_d = (pad_n <= 7'd55);
            pend_d  = (pad_n > 7'd55);
            full_d  = (pad_n == 7'd64);
          end else if (idx_q == 6'd63) begin
            blk_d   = pad_blk;
            final_d = 1'b0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      SEND: begin
        if (hshake) begin
          first_d = final_q;
          if (!pend_q) begin
            buf_d = '0;
            idx_d = '0;
            if (final_q) cnt_d = '0;
          end
        end
      end
      PAD: begin
        blk_d   = pad_blk;
        final_d = 1'b1;
        pend_d  = 1'b0;
        full_d  = 1'b0;
        buf_d   = '0;
        idx_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      first_q <= 1'b1;
      final_q <= 1'b0;
      pend_q  <= 1'b0;
      full_q  <= 1'b0;
      en_q    <= 1'b0;
`ifdef SHA256_LOADER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      first_q <= first_d;
      final_q <= final_d;
      pend_q  <= pend_d;
      full_q  <= full_d;
      en_q    <= 1'b1;
`ifdef SHA256_LOADER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_sha256_block_loader.sv
// Self-checking bench for sha256_block_loader. Expected blocks come from a
// plain SHA-256 padding model (append 0x80, zero-fill to 56 mod 64, append
// 64-bit bit length, cut into 64-byte blocks).
module tb_sha256_block_loader;

  typedef logic [0:511] blk_t;
  typedef logic [7:0]   bq_t[$];

  logic       clk;
  logic       rst;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_last;
  logic       byte_ready;
  blk_t       block_out;
  logic       block_valid;
  logic       block_ready;
  logic       block_first;
  logic       block_final;
`ifdef SHA256_LOADER_OVF_EN
  logic       len_ovf;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  sha256_block_loader #(.LEN_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_last   (byte_last),
    .byte_ready  (byte_ready),
    .block_out   (block_out),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_first (block_first),
    .block_final (block_final)
`ifdef SHA256_LOADER_OVF_EN
    ,
    .len_ovf     (len_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  function automatic void model(input bq_t m, output blk_t q[$]);
    bq_t         p;
    logic [63:0] bits;
    blk_t        v;
    p = m;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(m.size()) * 64'd8;
    for (int j = 7; j >= 0; j--) p.push_back(bits[8*j +: 8]);
    q = {};
    for (int b = 0; b < p.size() / 64; b++) begin
      for (int k = 0; k < 64; k++) v[8*k +: 8] = p[64*b + k];
      q.push_back(v);
    end
  endfunction

  // Drives a whole message and checks every cycle a block is presented.
  task automatic run_msg(input bq_t m, input bit dense, input string tag);
    blk_t ex[$];
    int   i   = 0;
    int   nb  = 0;
    int   cyc = 0;
    model(m, ex);
    while ((i < m.size() || nb < ex.size()) && cyc < 5000) begin
      byte_valid  = (i < m.size()) && (dense || $urandom_range(0, 3) != 0);
      byte_in     = (i < m.size()) ? m[i] : 8'h00;
      byte_last   = (i == m.size() - 1);
      block_ready = dense || ($urandom_range(0, 2) != 0);
      if (block_valid && nb < ex.size()) begin
        chk({tag, " blk"},   block_out,   ex[nb]);
        chk({tag, " first"}, block_first, nb == 0);
        chk({tag, " final"}, block_final, nb == ex.size() - 1);
        chk({tag, " rdy0"},  byte_ready,  1'b0);
        if (block_ready) nb++;
      end
      if (byte_valid && byte_ready) i++;
      @(negedge clk);
      cyc++;
    end
    byte_valid  = 1'b0;
    byte_last   = 1'b0;
    block_ready = 1'b0;
    chk({tag, " done"}, cyc < 5000, 1'b1);
    chk({tag, " idle"}, block_valid, 1'b0);
  endtask

  // Feeds bytes back-to-back with the block side stalled.
  task automatic feed_bytes(input bq_t m, input string tag);
    int i   = 0;
    int cyc = 0;
    block_ready = 1'b0;
    while (i < m.size() && cyc < 500) begin
      byte_valid = 1'b1;
      byte_in    = m[i];
      byte_last  = (i == m.size() - 1);
      if (byte_ready) i++;
      @(negedge clk);
      cyc++;
    end
    byte_valid = 1'b0;
    byte_last  = 1'b0;
    chk({tag, " feed"}, cyc < 500, 1'b1);
  endtask

  initial begin
    bq_t  msg;
    blk_t abc_blk;
    abc_blk = {32'h61626380, 416'd0, 64'h18};

    byte_in = 8'h00; byte_valid = 1'b0; byte_last = 1'b0; block_ready = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst valid", block_valid, 1'b0);
    chk("rst ready", byte_ready,  1'b0);
    chk("rst first", block_first, 1'b1);
    chk("rst final", block_final, 1'b0);
    chk("rst block", block_out,   '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("rel ready pre", byte_ready, 1'b0);
    @(negedge clk);
    chk("rel ready", byte_ready, 1'b1);

    // "abc" with block_ready held low for 5 cycles
    msg = {8'h61, 8'h62, 8'h63};
    feed_bytes(msg, "abc bp");
    for (int c = 0; c < 5; c++) begin
      chk("bp valid", block_valid, 1'b1);
      chk("bp block", block_out,   abc_blk);
      chk("bp ready", byte_ready,  1'b0);
      chk("bp first", block_first, 1'b1);
      chk("bp final", block_final, 1'b1);
      @(negedge clk);
    end
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
    chk("bp taken", block_valid, 1'b0);
    chk("bp fill",  byte_ready,  1'b1);

    msg = {};
    for (int k = 0; k < 55; k++) msg.push_back(8'h61);
    run_msg(msg, 1'b0, "len55");
    msg.push_back(8'h61);
    run_msg(msg, 1'b0, "len56");
    msg = {};
    for (int k = 0; k < 30; k++) begin
      msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    end
    run_msg(msg, 1'b0, "abc30");
    msg = {};
    for (int k = 0; k < 64; k++) msg.push_back(8'(k));
    run_msg(msg, 1'b1, "len64");
    msg = {8'h5a};
    run_msg(msg, 1'b1, "len1");
    msg = {};
    for (int k = 0; k < 63; k++) msg.push_back(8'($urandom));
    run_msg(msg, 1'b0, "len63");

    // Reset while a 56-byte message sits in SEND
    msg = {};
    for (int k = 0; k < 56; k++) msg.push_back(8'h61);
    feed_bytes(msg, "rst56");
    chk("rst56 send", block_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst56 valid", block_valid, 1'b0);
    chk("rst56 first", block_first, 1'b1);
    chk("rst56 block", block_out,   '0);
    chk("rst56 ready", byte_ready,  1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst56 fill", byte_ready, 1'b1);
    msg = {8'h61, 8'h62, 8'h63};
    run_msg(msg, 1'b1, "abc post");

    for (int r = 0; r < 12; r++) begin
      msg = {};
      for (int k = 0; k < int'($urandom_range(1, 150)); k++) msg.push_back(8'($urandom));
      run_msg(msg, r[0], "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
